// File: rtl/wash_sequencer.sv
// wash_sequencer
//   Washer program sequencer. Runs the enabled stages (wash, rinse x N, spin)
//   as 1 s countdowns derived from an internal prescaler. Drives the fill and
//   drain valves and reports the stage and the remaining per-stage and total
//   time. While idle, it continuously previews the program selected on the
//   front panel.
//
//   Ports
//     clk, rst        system clock, asynchronous active-high reset
//     start           level-sampled start request (honoured only in IDLE)
//     pause           single-cycle pulse, toggles RUN <-> PAUSE
//     abort           return to IDLE without a completion pulse
//     mode[2:0]       stage enables: bit0 wash, bit1 rinse, bit2 spin
//     level[LW-1:0]   water level, which scales the stage durations
//     rinses[1:0]     rinse repetitions (0 behaves as 1)
//     stage[1:0]      0 wash, 1 rinse, 2 spin, 3 none
//     rinse_idx[1:0]  current rinse repetition, 0-based
//     stage_time      seconds left in the current stage
//     total_time      seconds left in the whole program
//     in_water        fill valve command
//     out_water       drain valve command
//     busy            high in RUN or PAUSE
//     done            one-cycle pulse on normal completion
//
//   state | meaning
//   IDLE  | previewing live config, valves closed
//   RUN   | prescaler running, seconds counting down through enabled stages
//   PAUSE | prescaler, times and stage frozen, valves closed

module wash_sequencer #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int LW         = 3,
    parameter int TW         = 7,
    parameter int WASH_BASE  = 9,
    parameter int RINSE_BASE = 9,
    parameter int SPIN_BASE  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pause,
    input  logic          abort,
    input  logic [2:0]    mode,
    input  logic [LW-1:0] level,
    input  logic [1:0]    rinses,
    output logic [1:0]    stage,
    output logic [1:0]    rinse_idx,
    output logic [TW-1:0] stage_time,
    output logic [TW+2:0] total_time,
    output logic          in_water,
    output logic          out_water,
    output logic          busy,
    output logic          done
);

    localparam int TTW = TW + 3;
    localparam int PW  = $clog2(TICK_DIV);

    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);
    localparam logic [TW-1:0]  ONE_T      = TW'(1);
    localparam logic [TTW-1:0] ONE_TT     = TTW'(1);

    localparam logic [1:0] ST_WASH  = 2'd0;
    localparam logic [1:0] ST_RINSE = 2'd1;
    localparam logic [1:0] ST_SPIN  = 2'd2;
    localparam logic [1:0] ST_NONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    function automatic logic [TW-1:0] stage_dur(input logic [1:0] stg,
                                                input logic [LW-1:0] lvl);
        logic [TW-1:0] lv;
        lv = TW'(lvl);
        case (stg)
            ST_WASH:  stage_dur = TW'(WASH_BASE) + lv;
            ST_RINSE: stage_dur = TW'(RINSE_BASE) + (lv << 1);
            ST_SPIN:  stage_dur = TW'(SPIN_BASE) + lv;
            default:  stage_dur = '0;
        endcase
    endfunction

    // Lowest-numbered enabled stage at or after 'from', ST_NONE if none left.
    function automatic logic [1:0] first_from(input logic [2:0] msk, input int from);
        first_from = ST_NONE;
        for (int i = 2; i >= 0; i--) begin
            if (i >= from && msk[i]) first_from = 2'(i);
        end
    endfunction

    function automatic logic [TTW-1:0] prog_total(input logic [2:0] msk,
                                                  input logic [LW-1:0] lvl,
                                                  input logic [1:0] reps);
        logic [TTW-1:0] t;
        t = '0;
        if (msk[0]) t = t + TTW'(stage_dur(ST_WASH, lvl));
        if (msk[1]) t = t + TTW'(stage_dur(ST_RINSE, lvl)) * TTW'(reps);
        if (msk[2]) t = t + TTW'(stage_dur(ST_SPIN, lvl));
        prog_total = t;
    endfunction

    // Returns {in_water, out_water} for a running stage. Rinse first drains
    // for level+3 s, then fills for level s; the windows never overlap.
    function automatic logic [1:0] run_valves(input logic [1:0] stg,
                                              input logic [TW-1:0] st_time,
                                              input logic [LW-1:0] lvl);
        logic [TW-1:0] lv;
        logic [TW-1:0] el;
        logic [TW-1:0] drain_end;
        lv        = TW'(lvl);
        el        = stage_dur(stg, lvl) - st_time;
        drain_end = lv + TW'(3);
        case (stg)
            ST_WASH:  run_valves = {el < lv, 1'b0};
            ST_RINSE: run_valves = {(el >= drain_end) && (el < drain_end + lv),
                                    el < drain_end};
            ST_SPIN:  run_valves = 2'b01;
            default:  run_valves = 2'b00;
        endcase
    endfunction

    state_t         state, state_nxt;
    logic [PW-1:0]  presc, presc_nxt;
    logic [2:0]     mode_l, mode_l_nxt;
    logic [LW-1:0]  level_l, level_l_nxt;
    logic [1:0]     reps_l, reps_l_nxt;

    logic [1:0]     stage_nxt;
    logic [1:0]     rinse_idx_nxt;
    logic [TW-1:0]  stage_time_nxt;
    logic [TTW-1:0] total_time_nxt;
    logic           in_water_nxt;
    logic           out_water_nxt;
    logic           busy_nxt;
    logic           done_nxt;

    logic [1:0]     live_reps;
    logic [1:0]     pv_stage;
    logic [TW-1:0]  pv_time;
    logic [TTW-1:0] pv_total;
    logic [1:0]     after_stage;

    // Preview of the program selected on the live inputs.
    always_comb begin
        live_reps = (rinses == 2'd0) ? 2'd1 : rinses;
        pv_stage  = first_from(mode, 0);
        pv_time   = stage_dur(pv_stage, level);
        pv_total  = prog_total(mode, level, live_reps);
    end

    always_comb begin
        state_nxt      = state;
        presc_nxt      = presc;
        mode_l_nxt     = mode_l;
        level_l_nxt    = level_l;
        reps_l_nxt     = reps_l;
        stage_nxt      = stage;
        rinse_idx_nxt  = rinse_idx;
        stage_time_nxt = stage_time;
        total_time_nxt = total_time;
        done_nxt       = 1'b0;
        after_stage    = ST_NONE;

        unique case (state)
            S_IDLE: begin
                presc_nxt      = '0;
                stage_nxt      = pv_stage;
                stage_time_nxt = pv_time;
                total_time_nxt = pv_total;
                rinse_idx_nxt  = 2'd0;
                if (start && (mode != 3'b000) && !abort) begin
                    state_nxt   = S_RUN;
                    mode_l_nxt  = mode;
                    level_l_nxt = level;
                    reps_l_nxt  = live_reps;
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_nxt      = S_IDLE;
                    presc_nxt      = '0;
                    stage_nxt      = pv_stage;
                    stage_time_nxt = pv_time;
                    total_time_nxt = pv_total;
                    rinse_idx_nxt  = 2'd0;
                end else if (pause) begin
                    // A pause landing on a tick swallows it; prescaler holds.
                    state_nxt = S_PAUSE;
                end else if (presc == PRESC_LAST) begin
                    presc_nxt      = '0;
                    total_time_nxt = total_time - ONE_TT;
                    if (stage_time > ONE_T) begin
                        stage_time_nxt = stage_time - ONE_T;
                    end else if ((stage == ST_RINSE) && (rinse_idx < reps_l - 2'd1)) begin
                        rinse_idx_nxt  = rinse_idx + 2'd1;
                        stage_time_nxt = stage_dur(ST_RINSE, level_l);
                    end else begin
                        after_stage = first_from(mode_l, int'(stage) + 1);
                        if (after_stage == ST_NONE) begin
                            state_nxt      = S_IDLE;
                            stage_nxt      = ST_NONE;
                            stage_time_nxt = '0;
                            rinse_idx_nxt  = 2'd0;
                            done_nxt       = 1'b1;
                        end else begin
                            stage_nxt      = after_stage;
                            stage_time_nxt = stage_dur(after_stage, level_l);
                            rinse_idx_nxt  = 2'd0;
                        end
                    end
                end else begin
                    presc_nxt = presc + PRESC_ONE;
                end
            end

            S_PAUSE: begin
                if (abort) begin
                    state_nxt      = S_IDLE;
                    presc_nxt      = '0;
                    stage_nxt      = pv_stage;
                    stage_time_nxt = pv_time;
                    total_time_nxt = pv_total;
                    rinse_idx_nxt  = 2'd0;
                end else if (pause) begin
                    state_nxt = S_RUN;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);

        // Valves follow the next-state time so they line up with the registered
        // stage_time; anything other than RUN keeps both valves shut.
        if (state_nxt == S_RUN) begin
            {in_water_nxt, out_water_nxt} = run_valves(stage_nxt, stage_time_nxt, level_l_nxt);
        end else begin
            in_water_nxt  = 1'b0;
            out_water_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            presc      <= '0;
            mode_l     <= 3'b000;
            level_l    <= '0;
            reps_l     <= 2'd1;
            stage      <= ST_NONE;
            rinse_idx  <= 2'd0;
            stage_time <= '0;
            total_time <= '0;
            in_water   <= 1'b0;
            out_water  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            mode_l     <= mode_l_nxt;
            level_l    <= level_l_nxt;
            reps_l     <= reps_l_nxt;
            stage      <= stage_nxt;
            rinse_idx  <= rinse_idx_nxt;
            stage_time <= stage_time_nxt;
            total_time <= total_time_nxt;
            in_water   <= in_water_nxt;
            out_water  <= out_water_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Parametrised washer program sequencer. It replaces the fixed six-mode timer with a stage-enable mask, configurable base durations, 1–3 repeated rinses and an internal 1 Hz prescaler. It sits between the front-panel control (start/pause/abort, mode, water level) and the display and valve drivers. It outputs the current stage, per-stage and total remaining seconds, fill/drain valve commands, and a completion pulse.

## Interface

**Parameters**
- `TICK_DIV`, 100_000_000: clk cycles per 1 s tick (≥2).
- `LW`, 3: water-level width.
- `TW`, 7: stage-time width. Must hold `RINSE_BASE + 2*(2^LW-1)`.
- `WASH_BASE`, 9: wash duration = `WASH_BASE + level`.
- `RINSE_BASE`, 9: rinse duration = `RINSE_BASE + 2*level`. Must be ≥4.
- `SPIN_BASE`, 3: spin duration = `SPIN_BASE + level`.

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level-sampled; starts program from IDLE.
- `pause` in 1: single-cycle pulse; toggles RUN↔PAUSE.
- `abort` in 1: returns to IDLE from any state.
- `mode` in 3: stage enable mask. bit0 = wash, bit1 = rinse, bit2 = spin.
- `level` in LW: water level.
- `rinses` in 2: rinse repetitions. 0 is treated as 1.
- `stage` out 2: 0 = wash, 1 = rinse, 2 = spin, 3 = none.
- `rinse_idx` out 2: current rinse number, 0-based.
- `stage_time` out TW: remaining seconds in current stage.
- `total_time` out TW+3: remaining seconds in the whole program.
- `in_water`, `out_water` out 1: fill and drain valve commands.
- `busy` out 1: high in RUN or PAUSE.
- `done` out 1: one-cycle pulse at program completion.

## Operation

**States:** IDLE, RUN, PAUSE.

**IDLE**
- Each cycle, registers a preview from the live `mode`, `level` and `rinses`:
  - `stage` = first enabled stage, or 3 if `mode` = 0.
  - `stage_time` = that stage's duration, or 0.
  - `total_time` = wash + rinses_eff·rinse + spin, counting enabled stages only.
- Valves are 0. `rinse_idx` = 0.

**IDLE → RUN**
- Occurs on `start`=1 with `mode`≠0.
- Latches `mode`, `level` and `rinses_eff`. Clears the prescaler.
- While busy, further changes on the config inputs are ignored.
- `start` with `mode`=0 is ignored. `start` in RUN or PAUSE is ignored.

**RUN**
- The prescaler counts 0..TICK_DIV-1. A tick occurs when it equals TICK_DIV-1.
- On a tick, `total_time` decrements.
- On a tick with `stage_time`>1, `stage_time` decrements.
- On a tick with `stage_time`=1, the block advances:
  - From rinse with `rinse_idx` < rinses_eff-1: increment `rinse_idx`, reload the rinse duration.
  - Otherwise: move to the next enabled stage in order wash→rinse→spin and load its duration. `rinse_idx` resets to 0 on entering rinse.
  - If no stage remains: go to IDLE and pulse `done` in the same cycle as the transition. The IDLE preview resumes the next cycle.

**PAUSE**
- Entered and left by a `pause` pulse.
- Prescaler, times and stage are frozen.
- Both valves are forced to 0 (safety; this differs from the previous generation).

**Abort**
- `abort`=1 in RUN or PAUSE goes to IDLE next cycle. No `done` pulse.

**Priority:** rst > abort > pause > tick.
- A `pause` in the same cycle as a tick cancels that tick: no decrement, and the prescaler holds.

**Valves in RUN** (elapsed = stage duration − `stage_time`)
- Wash: `in_water` = (elapsed < level). `out_water` = 0.
- Rinse:
  - Drain phase: `out_water` = (elapsed < level+3).
  - Fill phase: `in_water` = (level+3 ≤ elapsed < 2·level+3).
  - Mutually exclusive.
- Spin: `out_water` = 1, `in_water` = 0.

**Arithmetic**
- All sums are unsigned, at full width TW+3. No wrap is possible under the parameter constraints.

## Timing

**Reset values:**
- State IDLE, prescaler 0.
- `stage` = 3, `rinse_idx` = 0, `stage_time` = 0, `total_time` = 0.
- `in_water` = 0, `out_water` = 0, `busy` = 0, `done` = 0.
- The first preview appears one cycle after `rst` deasserts.

**Latency**
- All outputs are registered; valves are registered from the next-state time.
- `start` in cycle n: `busy` = 1 at n+1. First tick occurs at cycle n+TICK_DIV.
- A stage transition and its reload appear in the same cycle as the tick that ends the prior stage.
- `total_time` reaches 0 on the final tick, together with `done` = 1 and `busy` = 0.

**Mid-operation reset:** `rst` asserted mid-run clears everything immediately (asynchronous). No `done` pulse.

## Test plan

1. **Full program, 2 rinses.** TICK_DIV=4, `mode`=111, `level`=2, `rinses`=2, `start`.
   - Required: wash 11 s, rinse 13 s ×2, spin 5 s.
   - Initial `total_time` = 42.
   - `done` pulses on the tick where `total_time` reaches 0, 168 cycles after `busy` rises.
2. **Spin only.** `mode`=100, `level`=0.
   - Required: `stage` = 2, `stage_time` = 3, `out_water` = 1 throughout.
   - `done` follows 3 ticks later.
3. **Rinse valve windows.** `mode`=010, `level`=1.
   - Required: rinse 11 s.
   - `out_water` = 1 for elapsed 0–3, `in_water` = 1 for elapsed 4, both 0 for elapsed 5–10.
4. **Pause during wash fill.**
   - Required: valves drop to 0 and times freeze for the whole pause.
   - After resume, the remaining ticks are intact and `total_time` continues from the held value.
   - Pause coinciding with a tick: no decrement.
5. **Abort mid-rinse and `mode`=0 start.**
   - Abort: IDLE next cycle, `done` never pulses, preview restored.
   - `start` with `mode`=0: `busy` stays 0.
6. **Reset mid-spin and config changes while busy.**
   - Async `rst` mid-spin: outputs go to reset values immediately.
   - Changing `mode`/`level` while busy: no effect on durations.
